// File: rtl/mips_harvard_cpu.sv
// mips_harvard_cpu: single-cycle MIPS I integer subset with Harvard instruction/data ports
//   clk, reset (async, active-high), clock_enable (0 freezes all state)
//   active: 1 while running, 0 after the jump to address 0
//   register_v0: live $2
//   instr_address/instr_readdata: combinational instruction fetch at PC
//   data_address/data_read/data_write/data_writedata/data_readdata: word load/store port,
//   combinational read and write on the clk edge
module mips_harvard_cpu #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clock_enable,
   output logic        active,
   output logic [31:0] register_v0,
   output logic [31:0] instr_address,
   input  logic [31:0] instr_readdata,
   output logic [31:0] data_address,
   output logic        data_write,
   output logic        data_read,
   output logic [31:0] data_writedata,
   input  logic [31:0] data_readdata
);
   logic [31:0] pc, npc;
   logic [31:0] gpr [32];
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt, sh, wr_addr;
   logic [15:0] imm;
   logic [31:0] rs_v, rt_v, simm, zimm, wr_data, target;
   logic        wr_en, taken, run;
   assign op = instr_readdata[31:26];
   assign rs = instr_readdata[25:21];
   assign rt = instr_readdata[20:16];
   assign rd = instr_readdata[15:11];
   assign shamt = instr_readdata[10:6];
   assign funct = instr_readdata[5:0];
   assign imm = instr_readdata[15:0];
   assign simm = {{16{imm[15]}}, imm};
   assign zimm = {16'h0, imm};
   // $0 is never written, so it always reads back as zero
   assign rs_v = gpr[rs];
   assign rt_v = gpr[rt];
   // funct[2] selects the variable shift forms
   assign sh = funct[2] ? rs_v[4:0] : shamt;
   assign run = clock_enable & active & ~reset;
   assign instr_address = pc;
   assign register_v0 = gpr[2];
   assign data_address = rs_v + simm;
   assign data_writedata = rt_v;
   assign data_write = run & (op == 6'h2B);
   assign data_read = run & (op == 6'h23);
   always_comb begin
      wr_en = 1'b0;
      wr_addr = rt;
      wr_data = 32'h0;
      taken = 1'b0;
      // npc is the delay-slot PC, so relative targets and links are based on it
      target = npc + {simm[29:0], 2'b00};
      case (op)
         6'h00: begin
            wr_en = 1'b1;
            wr_addr = rd;
            case (funct)
               6'h00, 6'h04: wr_data = rt_v << sh;
               6'h02, 6'h06: wr_data = rt_v >> sh;
               6'h03, 6'h07: wr_data = $signed(rt_v) >>> sh;
               6'h08: begin wr_en = 1'b0; taken = 1'b1; target = rs_v; end
               6'h09: begin taken = 1'b1; target = rs_v; wr_data = npc + 32'd4; end
               6'h21: wr_data = rs_v + rt_v;
               6'h23: wr_data = rs_v - rt_v;
               6'h24: wr_data = rs_v & rt_v;
               6'h25: wr_data = rs_v | rt_v;
               6'h26: wr_data = rs_v ^ rt_v;
               6'h27: wr_data = ~(rs_v | rt_v);
               6'h2A: wr_data = {31'h0, $signed(rs_v) < $signed(rt_v)};
               6'h2B: wr_data = {31'h0, rs_v < rt_v};
               default: wr_en = 1'b0;
            endcase
         end
         6'h01: taken = (rt == 5'd0) ? rs_v[31] : (rt == 5'd1) ? ~rs_v[31] : 1'b0;
         6'h02: begin taken = 1'b1; target = {npc[31:28], instr_readdata[25:0], 2'b00}; end
         6'h03: begin
            taken = 1'b1;
            target = {npc[31:28], instr_readdata[25:0], 2'b00};
            wr_en = 1'b1;
            wr_addr = 5'd31;
            wr_data = npc + 32'd4;
         end
         6'h04: taken = rs_v == rt_v;
         6'h05: taken = rs_v != rt_v;
         6'h06: taken = rs_v[31] | (rs_v == 32'h0);
         6'h07: taken = ~rs_v[31] & (rs_v != 32'h0);
         6'h09: begin wr_en = 1'b1; wr_data = rs_v + simm; end
         6'h0A: begin wr_en = 1'b1; wr_data = {31'h0, $signed(rs_v) < $signed(simm)}; end
         6'h0B: begin wr_en = 1'b1; wr_data = {31'h0, rs_v < simm}; end
         6'h0C: begin wr_en = 1'b1; wr_data = rs_v & zimm; end
         6'h0D: begin wr_en = 1'b1; wr_data = rs_v | zimm; end
         6'h0E: begin wr_en = 1'b1; wr_data = rs_v ^ zimm; end
         6'h0F: begin wr_en = 1'b1; wr_data = {imm, 16'h0}; end
         6'h23: begin wr_en = 1'b1; wr_data = data_readdata; end
         default: wr_en = 1'b0;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_VECTOR;
         npc <= RESET_VECTOR + 32'd4;
         active <= 1'b1;
         for (int i = 0; i < 32; i++) gpr[i] <= 32'h0;
      end else if (run) begin
         if (wr_en && wr_addr != 5'd0) gpr[wr_addr] <= wr_data;
         pc <= npc;
         npc <= taken ? target : npc + 32'd4;
         // PC becoming zero is the halt condition
         if (npc == 32'h0) active <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mips_harvard_cpu.sv
// tb_mips_harvard_cpu: directed programs with hand-computed $v0 results
module tb_mips_harvard_cpu;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clock_enable = 1'b1;
   logic        active, data_write, data_read;
   logic [31:0] register_v0, instr_address, instr_readdata;
   logic [31:0] data_address, data_writedata, data_readdata, offset;
   logic [31:0] rom [16];
   logic [31:0] dmem [16];
   int          errors = 0, checks = 0, cyc, wcnt;
   logic [31:0] waddr;
   logic        seen;
   mips_harvard_cpu dut (
      .clk(clk), .reset(reset), .clock_enable(clock_enable), .active(active),
      .register_v0(register_v0), .instr_address(instr_address), .instr_readdata(instr_readdata),
      .data_address(data_address), .data_write(data_write), .data_read(data_read),
      .data_writedata(data_writedata), .data_readdata(data_readdata)
   );
   always #5 clk = ~clk;
   assign offset = instr_address - 32'hBFC00000;
   assign instr_readdata = (offset < 32'd64) ? rom[offset[5:2]] : 32'h0;
   assign data_readdata = dmem[data_address[5:2]];
   always @(posedge clk) if (data_write) dmem[data_address[5:2]] <= data_writedata;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic boot();
      reset = 1'b1;
      clock_enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask
   task automatic run_to_halt();
      cyc = 0;
      wcnt = 0;
      waddr = 32'h0;
      while (active && cyc < 60) begin
         if (data_write) begin wcnt++; waddr = instr_address; end
         @(negedge clk);
         cyc++;
      end
      check("timeout", {31'h0, active}, 32'h0);
      check("halt_pc", instr_address, 32'h0);
   endtask
   initial begin
      rom = '{default: 32'h0};
      dmem = '{default: 32'h0};
      rom[0] = 32'h24020005;
      rom[1] = 32'h00000008;
      @(negedge clk);
      check("rst_pc", instr_address, 32'hBFC00000);
      check("rst_active", {31'h0, active}, 32'h1);
      check("rst_v0", register_v0, 32'h0);
      check("rst_strobes", {30'h0, data_write, data_read}, 32'h0);
      reset = 1'b0;
      check("rel_pc0", instr_address, 32'hBFC00000);
      @(negedge clk);
      check("rel_pc1", instr_address, 32'hBFC00004);
      check("rel_v0", register_v0, 32'h5);
      boot();
      run_to_halt();
      check("addiu_cycles", cyc, 3);
      check("addiu_v0", register_v0, 32'h5);
      repeat (3) @(negedge clk);
      check("frozen_pc", instr_address, 32'h0);
      check("frozen_v0", register_v0, 32'h5);
      rom = '{default: 32'h0};
      rom[0] = 32'h3C021234;
      rom[1] = 32'h34425678;
      rom[2] = 32'h00000008;
      boot();
      run_to_halt();
      check("lui_ori_v0", register_v0, 32'h12345678);
      rom = '{default: 32'h0};
      rom[0] = 32'h24030055;
      rom[1] = 32'hAC830000;
      rom[2] = 32'h8C820000;
      rom[3] = 32'h00000008;
      boot();
      run_to_halt();
      check("sw_lw_v0", register_v0, 32'h55);
      check("sw_count", wcnt, 1);
      check("sw_pc", waddr, 32'hBFC00004);
      check("sw_mem", dmem[0], 32'h55);
      rom = '{default: 32'h0};
      rom[0] = 32'h10000002;
      rom[1] = 32'h24020001;
      rom[2] = 32'h24020009;
      rom[3] = 32'h24420002;
      rom[4] = 32'h00000008;
      boot();
      run_to_halt();
      check("branch_v0", register_v0, 32'h3);
      rom = '{default: 32'h0};
      rom[0] = 32'h2403FFF0;
      rom[1] = 32'h00031083;
      rom[2] = 32'h00000008;
      boot();
      run_to_halt();
      check("sra_v0", register_v0, 32'hFFFFFFFC);
      rom = '{default: 32'h0};
      rom[0] = 32'h0FF00004;
      rom[4] = 32'h03E01021;
      rom[5] = 32'h00000008;
      boot();
      run_to_halt();
      check("jal_link_v0", register_v0, 32'hBFC00008);
      rom = '{default: 32'h0};
      rom[0] = 32'h3C021234;
      rom[1] = 32'h34425678;
      rom[2] = 32'h00000008;
      boot();
      @(negedge clk);
      clock_enable = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen = seen | data_write | data_read;
      end
      check("ce_pc", instr_address, 32'hBFC00004);
      check("ce_v0", register_v0, 32'h12340000);
      check("ce_strobes", {31'h0, seen}, 32'h0);
      clock_enable = 1'b1;
      run_to_halt();
      check("ce_final_v0", register_v0, 32'h12345678);
      rom = '{default: 32'h0};
      rom[0] = 32'h10000002;
      rom[1] = 32'h24020001;
      rom[2] = 32'h24020009;
      rom[3] = 32'h24420002;
      rom[4] = 32'h00000008;
      boot();
      repeat (2) @(negedge clk);
      check("pre_rst_v0", register_v0, 32'h1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_pc", instr_address, 32'hBFC00000);
      check("async_rst_v0", register_v0, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      run_to_halt();
      check("after_rst_v0", register_v0, 32'h3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
